instr_fetch: RTL and testbench

//  Producer side of the decoder's instruction interface. Holds the fetch PC.

---
 rtl/instr_fetch_pkg.sv | 32 +++
 rtl/ifetch_pc_reg.sv | 61 ++++++
 rtl/instr_fetch.sv | 150 +++++++++++++++
 tb/tb_instr_fetch.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_pkg.sv
// Shared types for the instruction fetch block: instr_t, fetch FSM states, NOP encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package instr_fetch_pkg;

   // RV32 R-type field view of a fetched word; other formats overlay the same bits
   typedef struct packed {
      logic [6:0] funct7;
      logic [4:0] rs2;
      logic [4:0] rs1;
      logic [2:0] funct3;
      logic [4:0] rd;
      logic [6:0] opcode;
   } instr_t;

   typedef enum logic [2:0] {
      IDLE,
      REQ,
      WAIT,
      HOLD,
      DRAIN
   } fetch_state_t;

   // addi x0, x0, 0
   localparam logic [31:0] NOP_WORD = 32'h0000_0013;

   // Sequential PC advance; wraps modulo 2^32
   function automatic logic [31:0] pc_add(input logic [31:0] pc, input int unsigned step);
      return pc + 32'(step);
   endfunction

endpackage

// File: rtl/ifetch_pc_reg.sv
// Fetch PC register: sequential increment, redirect mux, optional alignment check
// (alignment check built only when MMRV_IFETCH_ALIGN_CHECK_EN is defined).
// Latency: pc_next is combinational, fetch_pc follows it one cycle later; no backpressure.
module ifetch_pc_reg
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        advance,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic [31:0] fetch_pc,
   output logic [31:0] pc_next,
   output logic        redirect_fault,
   output logic        fetch_fault
);

   logic [31:0] target;

`ifdef MMRV_IFETCH_ALIGN_CHECK_EN
   // Misaligned targets are refused; the PC keeps its old value
   assign target         = redirect_pc;
   assign redirect_fault = redirect_valid & (redirect_pc[1:0] != 2'b00);

   // Sticky fault flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (rst)
         fetch_fault <= 1'b0;
      else if (redirect_fault)
         fetch_fault <= 1'b1;
   end
`else
   // Without the check the low bits are simply dropped
   assign target         = redirect_pc & ~32'h0000_0003;
   assign redirect_fault = 1'b0;
   assign fetch_fault    = 1'b0;
`endif

   // Redirect beats sequential advance; a refused redirect holds the PC
   always_comb begin
      pc_next = fetch_pc;
      if (redirect_valid) begin
         if (!redirect_fault)
            pc_next = target;
      end else if (advance) begin
         pc_next = pc_add(fetch_pc, PC_STEP);
      end
   end

   // PC register
   always_ff @(posedge clk) begin
      if (rst)
         fetch_pc <= RESET_PC;
      else
         fetch_pc <= pc_next;
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch producer: one outstanding imem read, presents instr/instr_pc to decoder.
// Latency: imem_rsp_valid in cycle N gives instr_valid in cycle N+1.
// Backpressure: instr held until instr_ready; no new request issued while holding.
// Optional: MMRV_IFETCH_ALIGN_CHECK_EN flags misaligned redirects and parks the fetcher.
module instr_fetch
   import instr_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output instr_t      instr,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr_pc,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        fetch_fault
);

   fetch_state_t state;
   logic         flush;
   logic         req_fire;
   logic         advance;
   logic         park;
   logic [31:0]  fetch_pc;
   logic [31:0]  pc_next;
   logic         redirect_fault;
   fetch_state_t go_state;
   logic         go_valid;

   ifetch_pc_reg #(
      .RESET_PC (RESET_PC),
      .PC_STEP  (PC_STEP)
   ) u_pc_reg (
      .clk            (clk),
      .rst            (rst),
      .advance        (advance),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_pc       (fetch_pc),
      .pc_next        (pc_next),
      .redirect_fault (redirect_fault),
      .fetch_fault    (fetch_fault)
   );

   assign req_fire = imem_req_valid & imem_req_ready;
   // PC only steps when a response is accepted into the instr register
   assign advance  = (state == WAIT) & imem_rsp_valid & ~redirect_valid;
   // A fault (already latched or raised this cycle) stops further requests
   assign park     = fetch_fault | redirect_fault;

   // Where to go once nothing is outstanding: issue the next request or park
   always_comb begin
      go_state = park ? IDLE : REQ;
      go_valid = ~park;
   end

   // Fetch FSM with registered request and instruction outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state          <= IDLE;
         flush          <= 1'b0;
         imem_req_valid <= 1'b0;
         imem_req_addr  <= RESET_PC;
         instr          <= NOP_WORD;
         instr_valid    <= 1'b0;
         instr_pc       <= RESET_PC;
      end else begin
         // Any redirect kills the presented instruction
         if (redirect_valid) begin
            instr_valid <= 1'b0;
            instr       <= NOP_WORD;
         end
         case (state)
            IDLE: begin
               state          <= go_state;
               imem_req_valid <= go_valid;
               imem_req_addr  <= pc_next;
            end
            REQ: begin
               if (req_fire) begin
                  // Stale request (redirect seen while offered) must be drained
                  imem_req_valid <= 1'b0;
                  flush          <= 1'b0;
                  state          <= (flush || redirect_valid) ? DRAIN : WAIT;
               end else if (park) begin
                  imem_req_valid <= 1'b0;
                  flush          <= 1'b0;
                  state          <= IDLE;
               end else if (redirect_valid) begin
                  // Keep address/valid stable; remember to drop the response
                  flush <= 1'b1;
               end
            end
            WAIT: begin
               if (redirect_valid) begin
                  if (imem_rsp_valid) begin
                     // Response arrived with the redirect: drop it, nothing outstanding
                     state          <= go_state;
                     imem_req_valid <= go_valid;
                     imem_req_addr  <= pc_next;
                  end else begin
                     state <= DRAIN;
                  end
               end else if (imem_rsp_valid) begin
                  instr       <= imem_rsp_data;
                  instr_pc    <= fetch_pc;
                  instr_valid <= 1'b1;
                  state       <= HOLD;
               end
            end
            HOLD: begin
               if (redirect_valid) begin
                  state          <= go_state;
                  imem_req_valid <= go_valid;
                  imem_req_addr  <= pc_next;
               end else if (instr_ready) begin
                  instr_valid    <= 1'b0;
                  state          <= go_state;
                  imem_req_valid <= go_valid;
                  imem_req_addr  <= pc_next;
               end
            end
            DRAIN: begin
               if (imem_rsp_valid) begin
                  state          <= go_state;
                  imem_req_valid <= go_valid;
                  imem_req_addr  <= pc_next;
               end
            end
            default: begin
               state          <= IDLE;
               imem_req_valid <= 1'b0;
            end
         endcase
      end
   end

   // Responses are only legal while one is outstanding
   rsp_in_window: assert property (@(posedge clk) disable iff (rst)
      imem_rsp_valid |-> (state == WAIT || state == DRAIN));

endmodule

// File: tb/tb_instr_fetch.sv
// Directed, table-driven bench for instr_fetch: one record per clock cycle.
// Latency: n/a.
// Backpressure: exercised via imem_req_ready and instr_ready vectors.
module tb_instr_fetch;
   import instr_fetch_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data = 32'h0;
   instr_t      instr;
   logic        instr_valid;
   logic        instr_ready = 1'b0;
   logic [31:0] instr_pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        fetch_fault;

   int checks = 0;
   int errors = 0;

   instr_fetch #(
      .RESET_PC (32'h0000_0000),
      .PC_STEP  (4)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .instr          (instr),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr_pc       (instr_pc),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .fetch_fault    (fetch_fault)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        rdy;
      logic        rv;
      logic [31:0] d;
      logic        ir;
      logic        rd;
      logic [31:0] rpc;
      logic        e_qv;
      logic [31:0] e_qa;
      logic        e_iv;
      logic [31:0] e_ins;
      logic [31:0] e_ipc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic rdy, input logic rv, input logic [31:0] d,
                               input logic ir, input logic rd, input logic [31:0] rpc,
                               input logic qv, input logic [31:0] qa, input logic iv,
                               input logic [31:0] ins, input logic [31:0] ipc);
      vec_t v;
      v.rst = r; v.rdy = rdy; v.rv = rv; v.d = d; v.ir = ir; v.rd = rd; v.rpc = rpc;
      v.e_qv = qv; v.e_qa = qa; v.e_iv = iv; v.e_ins = ins; v.e_ipc = ipc;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs at negedge, sample outputs 1 time unit after posedge
   task automatic drive(input logic r, input logic rdy, input logic rv, input logic [31:0] d,
                        input logic ir, input logic rd, input logic [31:0] rpc);
      @(negedge clk);
      rst = r; imem_req_ready = rdy; imem_rsp_valid = rv; imem_rsp_data = d;
      instr_ready = ir; redirect_valid = rd; redirect_pc = rpc;
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic qv, input logic [31:0] qa,
                             input logic iv, input logic [31:0] ins, input logic [31:0] ipc,
                             input logic flt);
      chk({tag, ".req_valid"}, {31'b0, imem_req_valid}, {31'b0, qv});
      if (qv) chk({tag, ".req_addr"}, imem_req_addr, qa);
      chk({tag, ".instr_valid"}, {31'b0, instr_valid}, {31'b0, iv});
      chk({tag, ".instr"}, instr, ins);
      chk({tag, ".instr_pc"}, instr_pc, ipc);
      chk({tag, ".fetch_fault"}, {31'b0, fetch_fault}, {31'b0, flt});
   endtask

   localparam logic [31:0] NOP = 32'h0000_0013;

   initial begin
      // rst rdy rv data ir rd rpc | qv qa iv instr ipc
      vecs.push_back(mk(1,0,0,32'h0,        0,0,32'h0,        0,32'h0,        0,NOP,          32'h0));
      vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        1,32'h0,        0,NOP,          32'h0));
      vecs.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        0,32'h0,        0,NOP,          32'h0));
      vecs.push_back(mk(0,0,1,32'h00500093, 0,0,32'h0,        0,32'h0,        1,32'h00500093, 32'h0));
      vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h4,        0,32'h00500093, 32'h0));
      vecs.push_back(mk(0,0,0,32'h0,        0,0,32'h0,        1,32'h4,        0,32'h00500093, 32'h0));
      vecs.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        0,32'h0,        0,32'h00500093, 32'h0));
      vecs.push_back(mk(0,0,1,32'h00100113, 0,0,32'h0,        0,32'h0,        1,32'h00100113, 32'h4));
      vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h8,        0,32'h00100113, 32'h4));
      vecs.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        0,32'h0,        0,32'h00100113, 32'h4));
      // redirect while waiting: DEADBEEF must be dropped
      vecs.push_back(mk(0,0,0,32'h0,        0,1,32'h100,      0,32'h0,        0,NOP,          32'h4));
      vecs.push_back(mk(0,0,1,32'hDEADBEEF, 0,0,32'h0,        1,32'h100,      0,NOP,          32'h4));
      vecs.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        0,32'h0,        0,NOP,          32'h4));
      vecs.push_back(mk(0,0,1,32'h00208193, 0,0,32'h0,        0,32'h0,        1,32'h00208193, 32'h100));
      vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h104,      0,32'h00208193, 32'h100));
      vecs.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        0,32'h0,        0,32'h00208193, 32'h100));
      // redirect and response in the same cycle
      vecs.push_back(mk(0,0,1,32'hCAFEF00D, 0,1,32'h200,      1,32'h200,      0,NOP,          32'h100));
      vecs.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        0,32'h0,        0,NOP,          32'h100));
      vecs.push_back(mk(0,0,1,32'h11111111, 0,0,32'h0,        0,32'h0,        1,32'h11111111, 32'h200));
      // redirect and instr_ready together: redirect wins
      vecs.push_back(mk(0,0,0,32'h0,        1,1,32'h300,      1,32'h300,      0,NOP,          32'h200));
      // redirect while request offered but not accepted
      vecs.push_back(mk(0,0,0,32'h0,        0,1,32'h400,      1,32'h300,      0,NOP,          32'h200));
      vecs.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        0,32'h0,        0,NOP,          32'h200));
      vecs.push_back(mk(0,0,1,32'h22222222, 0,0,32'h0,        1,32'h400,      0,NOP,          32'h200));
      // redirect in the handshake cycle
      vecs.push_back(mk(0,1,0,32'h0,        0,1,32'h500,      0,32'h0,        0,NOP,          32'h200));
      vecs.push_back(mk(0,0,1,32'h33333333, 0,0,32'h0,        1,32'h500,      0,NOP,          32'h200));
      vecs.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        0,32'h0,        0,NOP,          32'h200));
      vecs.push_back(mk(0,0,1,32'h44444444, 0,0,32'h0,        0,32'h0,        1,32'h44444444, 32'h500));
      vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h504,      0,32'h44444444, 32'h500));
      vecs.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        0,32'h0,        0,32'h44444444, 32'h500));
      vecs.push_back(mk(0,0,1,32'h55555555, 0,0,32'h0,        0,32'h0,        1,32'h55555555, 32'h504));
      // wrap-around of the fetch PC
      vecs.push_back(mk(0,0,0,32'h0,        0,1,32'hFFFFFFFC, 1,32'hFFFFFFFC, 0,NOP,          32'h504));
      vecs.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        0,32'h0,        0,NOP,          32'h504));
      vecs.push_back(mk(0,0,1,32'h66666666, 0,0,32'h0,        0,32'h0,        1,32'h66666666, 32'hFFFFFFFC));
      vecs.push_back(mk(0,0,0,32'h0,        1,0,32'h0,        1,32'h0,        0,32'h66666666, 32'hFFFFFFFC));
      vecs.push_back(mk(0,1,0,32'h0,        0,0,32'h0,        0,32'h0,        0,32'h66666666, 32'hFFFFFFFC));
      vecs.push_back(mk(0,0,1,32'h77777777, 0,0,32'h0,        0,32'h0,        1,32'h77777777, 32'h0));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].rdy, vecs[i].rv, vecs[i].d, vecs[i].ir, vecs[i].rd, vecs[i].rpc);
         check_outs($sformatf("vec%0d", i), vecs[i].e_qv, vecs[i].e_qa, vecs[i].e_iv,
                    vecs[i].e_ins, vecs[i].e_ipc, 1'b0);
      end

      // Downstream stall: instr held stable, no new request
      for (int k = 0; k < 5; k++) begin
         drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
         check_outs($sformatf("stall%0d", k), 1'b0, 32'h0, 1'b1, 32'h77777777, 32'h0, 1'b0);
      end
      drive(0, 0, 0, 32'h0, 1, 0, 32'h0);
      check_outs("stall_release", 1'b1, 32'h4, 1'b0, 32'h77777777, 32'h0, 1'b0);

      // Misaligned redirect while a request is offered
`ifdef MMRV_IFETCH_ALIGN_CHECK_EN
      drive(0, 0, 0, 32'h0, 0, 1, 32'h102);
      check_outs("misalign", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
         check_outs($sformatf("parked%0d", k), 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b1);
      end
`else
      drive(0, 0, 0, 32'h0, 0, 1, 32'h102);
      check_outs("misalign_offer", 1'b1, 32'h4, 1'b0, NOP, 32'h0, 1'b0);
      drive(0, 1, 0, 32'h0, 0, 0, 32'h0);
      check_outs("misalign_drain", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0);
      drive(0, 0, 1, 32'h88888888, 0, 0, 32'h0);
      check_outs("misalign_req", 1'b1, 32'h100, 1'b0, NOP, 32'h0, 1'b0);
`endif

      // Reset mid-flight returns everything to reset values, then fetch restarts at RESET_PC
      drive(1, 0, 0, 32'h0, 0, 0, 32'h0);
      check_outs("rst_again", 1'b0, 32'h0, 1'b0, NOP, 32'h0, 1'b0);
      drive(0, 0, 0, 32'h0, 0, 0, 32'h0);
      check_outs("restart", 1'b1, 32'h0, 1'b0, NOP, 32'h0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
